// File: rtl/adc_pkg.sv
// rtl/adc_pkg.sv - shared ADC stream constants, header layout and packer state
//
// Shared by adc_frame_packer, the FIFO drain logic and firmware header definitions.
//   ADC_HDR_MAGIC    : header tag byte, used by firmware to resync on frame starts
//   ADC_SAMPLE_W     : width of one channel sample in frame_data and data words
//   ADC_HDR_*_LSB    : bit offsets of the header fields
//   packer_state_e   : frame packer state
//   adc_make_header  : assembles a header word from its fields
package adc_pkg;

  localparam logic [7:0] ADC_HDR_MAGIC = 8'hA5;
  localparam int ADC_SAMPLE_W = 24;

  localparam int ADC_HDR_MAGIC_LSB = 24;
  localparam int ADC_HDR_SEQ_LSB   = 16;
  localparam int ADC_HDR_NCH_LSB   = 8;
  localparam int ADC_HDR_DROPS_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } packer_state_e;

  function automatic logic [31:0] adc_make_header(input logic [7:0] seq,
                                                  input logic [7:0] nch,
                                                  input logic [7:0] drops);
    logic [31:0] w;
    w = '0;
    w[ADC_HDR_MAGIC_LSB +: 8] = ADC_HDR_MAGIC;
    w[ADC_HDR_SEQ_LSB   +: 8] = seq;
    w[ADC_HDR_NCH_LSB   +: 8] = nch;
    w[ADC_HDR_DROPS_LSB +: 8] = drops;
    return w;
  endfunction

endpackage

// File: rtl/adc_frame_packer.sv
// rtl/adc_frame_packer.sv - packs one ADC frame into header + per-channel words for the stream FIFO
//
// A frame is accepted only in IDLE, with enable high and room in the FIFO for the
// whole frame, so the FIFO never holds a partial frame. Anything else is dropped
// and counted.
//   clk, rst          : clock, synchronous active-high reset
//   enable            : allow new frames to be accepted
//   frame_valid       : one-cycle strobe qualifying frame_data
//   frame_data        : NUM_CH samples of 24 bits, channel c at [24c+23:24c]
//   push_valid/data   : registered word offered to the FIFO
//   push_ready        : FIFO accepts the offered word
//   fifo_level        : current FIFO occupancy in words
//   busy              : frame emission in progress
//   frames_dropped    : saturating count of rejected frames
//   drop_clear        : zero frames_dropped
module adc_frame_packer
  import adc_pkg::*;
#(
  parameter int NUM_CH     = 8,
  parameter int FIFO_DEPTH = 64,
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           frame_valid,
  input  logic [NUM_CH*ADC_SAMPLE_W-1:0] frame_data,
  output logic                           push_valid,
  output logic [31:0]                    push_data,
  input  logic                           push_ready,
  input  logic [LVL_W-1:0]               fifo_level,
  output logic                           busy,
  output logic [15:0]                    frames_dropped,
  input  logic                           drop_clear
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  packer_state_e                  state_q;
  logic [CH_W-1:0]                ch_q;
  logic [7:0]                     seq_q;
  logic [7:0]                     drops_q;
  logic [NUM_CH*ADC_SAMPLE_W-1:0] frame_q;

  logic            space_ok;
  logic            accept;
  logic            drop;
  logic            hdr_hs;
  logic            last_ch;
  logic [CH_W-1:0] next_ch;
  logic [31:0]     next_word;

  // Widened to 32 bits so a fifo_level above FIFO_DEPTH simply reads as "no room".
  assign space_ok = (32'(fifo_level) + 32'(NUM_CH + 1)) <= 32'(FIFO_DEPTH);
  assign accept   = frame_valid & enable & (state_q == IDLE) & space_ok;
  assign drop     = frame_valid & ~accept;
  assign hdr_hs   = (state_q == HDR) & push_ready;
  assign last_ch  = (ch_q == CH_W'(NUM_CH - 1));
  assign busy     = (state_q != IDLE);

  // Channel whose word is loaded into push_data on the current handshake.
  assign next_ch = (state_q == HDR) ? '0 : ch_q + CH_W'(1);

  always_comb begin
    next_word = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (next_ch == CH_W'(i)) begin
        next_word = {8'(i), frame_q[i*ADC_SAMPLE_W +: ADC_SAMPLE_W]};
      end
    end
  end

  // push_valid/push_data are registered so they only change on a handshake or
  // a state change, never combinationally from frame_*. The header is captured
  // at accept time so it stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      ch_q           <= '0;
      seq_q          <= '0;
      drops_q        <= '0;
      frame_q        <= '0;
      push_valid     <= 1'b0;
      push_data      <= '0;
      frames_dropped <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            frame_q    <= frame_data;
            state_q    <= HDR;
            ch_q       <= '0;
            push_valid <= 1'b1;
            push_data  <= adc_make_header(seq_q, 8'(NUM_CH), drops_q);
          end
        end
        HDR: begin
          if (push_ready) begin
            state_q   <= DATA;
            ch_q      <= '0;
            push_data <= next_word;
          end
        end
        DATA: begin
          if (push_ready) begin
            if (last_ch) begin
              state_q    <= IDLE;
              ch_q       <= '0;
              push_valid <= 1'b0;
              push_data  <= '0;
            end else begin
              ch_q      <= next_ch;
              push_data <= next_word;
            end
          end
        end
        default: begin
          state_q    <= IDLE;
          ch_q       <= '0;
          push_valid <= 1'b0;
          push_data  <= '0;
        end
      endcase

      if (hdr_hs) begin
        seq_q <= seq_q + 8'd1;
      end

      // A drop coinciding with the header handshake belongs to the next header.
      if (hdr_hs) begin
        drops_q <= drop ? 8'd1 : 8'd0;
      end else if (drop && drops_q != 8'hFF) begin
        drops_q <= drops_q + 8'd1;
      end

      if (drop_clear) begin
        frames_dropped <= drop ? 16'd1 : 16'd0;
      end else if (drop && frames_dropped != 16'hFFFF) begin
        frames_dropped <= frames_dropped + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// tb/tb_adc_frame_packer.sv - self-checking bench for adc_frame_packer
module tb_adc_frame_packer;

  localparam int NCH   = 4;
  localparam int DEPTH = 64;
  localparam int LW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, enable, frame_valid, push_ready, drop_clear;
  logic [NCH*24-1:0] frame_data;
  logic [LW-1:0]     fifo_level;
  logic              push_valid, busy;
  logic [31:0]       push_data;
  logic [15:0]       frames_dropped;

  adc_frame_packer #(.NUM_CH(NCH), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .frame_valid(frame_valid),
    .frame_data(frame_data), .push_valid(push_valid), .push_data(push_data),
    .push_ready(push_ready), .fifo_level(fifo_level), .busy(busy),
    .frames_dropped(frames_dropped), .drop_clear(drop_clear)
  );

  logic          rst8, fv8, pv8, busy8;
  logic [191:0]  fd8;
  logic [31:0]   pd8;
  logic [15:0]   fdrop8;

  adc_frame_packer #(.NUM_CH(8), .FIFO_DEPTH(DEPTH)) u_dut8 (
    .clk(clk), .rst(rst8), .enable(1'b1), .frame_valid(fv8),
    .frame_data(fd8), .push_valid(pv8), .push_data(pd8),
    .push_ready(1'b1), .fifo_level({LW{1'b0}}), .busy(busy8),
    .frames_dropped(fdrop8), .drop_clear(1'b0)
  );

  int checks = 0;
  int errors = 0;

  // Transaction-level reference: a frame is a list of words, acceptance needs an
  // idle packer, enable and room for NCH+1 words; everything else is a drop.
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];
  int          m_pending;
  logic [7:0]  m_seq, m_drops;
  logic [15:0] m_fdrop;
  int          m_vmis;
  bit          m_dr, m_acc, m_hs;

  always @(negedge clk) begin
    if (rst) begin
      m_pending = 0; m_seq = 0; m_drops = 0; m_fdrop = 0; m_vmis = 0;
    end else begin
      if (push_valid !== (m_pending != 0)) m_vmis++;
      if (push_valid && push_ready) got_q.push_back(push_data);
      m_dr = 0; m_acc = 0;
      if (frame_valid) begin
        if (m_pending == 0 && enable && (DEPTH - int'(fifo_level)) >= NCH + 1) begin
          m_acc = 1;
          exp_q.push_back({8'hA5, m_seq, 8'(NCH), m_drops});
          for (int c = 0; c < NCH; c++) exp_q.push_back({8'(c), frame_data[c*24 +: 24]});
        end else begin
          m_dr = 1;
        end
      end
      m_hs = (m_pending == NCH + 1) && push_ready;
      if (m_pending != 0 && push_ready) m_pending--;
      if (m_acc) m_pending = NCH + 1;
      if (m_hs) begin
        m_seq++;
        m_drops = m_dr ? 8'd1 : 8'd0;
      end else if (m_dr && m_drops != 8'hFF) begin
        m_drops++;
      end
      if (drop_clear) m_fdrop = m_dr ? 16'd1 : 16'd0;
      else if (m_dr && m_fdrop != 16'hFFFF) m_fdrop++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; enable = 1; frame_valid = 0; push_ready = 1; drop_clear = 0;
    fifo_level = '0; frame_data = '0;
    tick(); tick();
    rst = 0;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1; enable = 1; frame_valid = 1; push_ready = 1; drop_clear = 0;
    fifo_level = '0; frame_data = {$urandom, $urandom, $urandom};
    tick(); frame_valid = 0; tick();
    checks++; if (push_valid !== 1'b0) begin errors++; $display("FAIL reset_push_valid got %0b exp 0", push_valid); end
    checks++; if (push_data !== 32'h0) begin errors++; $display("FAIL reset_push_data got %h exp 0", push_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (frames_dropped !== 16'h0) begin errors++; $display("FAIL reset_frames_dropped got %h exp 0", frames_dropped); end
    rst = 0;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_basic();
    logic [31:0] ew [5];
    int mis;
    ew = '{32'hA5000400, 32'h00000001, 32'h01FFFFFF, 32'h027FFFFF, 32'h03800000};
    do_reset();
    frame_data = {24'h800000, 24'h7FFFFF, 24'hFFFFFF, 24'h000001};
    frame_valid = 1; tick(); frame_valid = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (push_valid !== 1'b1 || push_data !== ew[i]) begin
        errors++; $display("FAIL basic_word%0d got v=%0b %h exp v=1 %h", i, push_valid, push_data, ew[i]);
      end
      tick();
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end got %0b exp 0", busy); end
    mis = 0;
    if (got_q.size() != exp_q.size()) mis = 1; else foreach (got_q[i]) if (got_q[i] !== exp_q[i]) mis++;
    checks++; if (mis != 0) begin errors++; $display("FAIL basic_stream got %0d words exp %0d (%0d bad)", got_q.size(), exp_q.size(), mis); end
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int mis, n;
    bit found;
    got_q.delete(); exp_q.delete();
    frame_data = {$urandom, $urandom, $urandom};
    frame_valid = 1; tick(); frame_valid = 0;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (push_valid && push_data[31:24] == 8'h01) found = 1; else tick();
    end
    checks++; if (!found) begin errors++; $display("FAIL bp_find_ch1 got none exp ch1 word"); end
    held = push_data;
    push_ready = 0;
    mis = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (push_valid !== 1'b1 || push_data !== held) mis++;
    end
    push_ready = 1;
    checks++; if (mis != 0 || held !== {8'h01, frame_data[47:24]}) begin
      errors++; $display("FAIL bp_hold got %h (%0d unstable) exp %h", held, mis, {8'h01, frame_data[47:24]});
    end
    n = 0; while (busy && n < 100) begin tick(); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_idle_timeout got busy=%0b exp 0", busy); end
    mis = 0;
    if (got_q.size() != exp_q.size()) mis = 1; else foreach (got_q[i]) if (got_q[i] !== exp_q[i]) mis++;
    checks++; if (mis != 0 || got_q.size() != NCH + 1) begin errors++; $display("FAIL bp_stream got %0d words exp %0d (%0d bad)", got_q.size(), exp_q.size(), mis); end
    checks++; if (got_q.size() == 0 || got_q[0][23:16] !== 8'd1) begin errors++; $display("FAIL bp_seq got %h exp seq 01", (got_q.size() > 0) ? got_q[0] : 32'h0); end
  endtask

  task automatic test_space_check();
    int n, mis;
    do_reset();
    fifo_level = LW'(DEPTH - 4);
    frame_data = {$urandom, $urandom, $urandom};
    frame_valid = 1; tick(); frame_valid = 0; tick();
    checks++; if (busy !== 1'b0 || frames_dropped !== 16'd1) begin errors++; $display("FAIL space_drop got busy=%0b dropped=%0d exp busy=0 dropped=1", busy, frames_dropped); end
    fifo_level = LW'(DEPTH - 5);
    frame_data = {$urandom, $urandom, $urandom};
    frame_valid = 1; tick(); frame_valid = 0;
    checks++; if (push_data !== 32'hA5000401) begin errors++; $display("FAIL space_hdr got %h exp a5000401", push_data); end
    n = 0; while (busy && n < 100) begin tick(); n++; end
    mis = 0;
    if (got_q.size() != exp_q.size()) mis = 1; else foreach (got_q[i]) if (got_q[i] !== exp_q[i]) mis++;
    checks++; if (mis != 0 || busy !== 1'b0) begin errors++; $display("FAIL space_stream got %0d words exp %0d (%0d bad)", got_q.size(), exp_q.size(), mis); end
    fifo_level = '0;
  endtask

  task automatic test_drop_during_frame();
    int mis;
    do_reset();
    frame_data = {$urandom, $urandom, $urandom};
    frame_valid = 1; tick(); frame_valid = 0;           // T+1
    tick(); tick();                                      // T+3: DATA
    frame_data = {$urandom, $urandom, $urandom};
    frame_valid = 1; tick(); frame_valid = 0;            // T+4
    tick();                                              // T+5: last data word
    frame_data = {$urandom, $urandom, $urandom};
    frame_valid = 1; tick(); frame_valid = 0;            // T+6
    checks++; if (busy !== 1'b0 || frames_dropped !== 16'd2) begin errors++; $display("FAIL during_drops got busy=%0b dropped=%0d exp busy=0 dropped=2", busy, frames_dropped); end
    mis = 0;
    if (got_q.size() != exp_q.size()) mis = 1; else foreach (got_q[i]) if (got_q[i] !== exp_q[i]) mis++;
    checks++; if (mis != 0 || got_q.size() != NCH + 1) begin errors++; $display("FAIL during_stream got %0d words exp %0d (%0d bad)", got_q.size(), NCH + 1, mis); end
    checks++; if (m_vmis != 0) begin errors++; $display("FAIL during_valid got %0d bad cycles exp 0", m_vmis); end
  endtask

  task automatic test_saturation();
    int n;
    do_reset();
    enable = 0; frame_valid = 1;
    repeat (300) tick();
    frame_valid = 0; enable = 1;
    checks++; if (frames_dropped !== 16'd300) begin errors++; $display("FAIL sat_count300 got %0d exp 300", frames_dropped); end
    frame_data = {$urandom, $urandom, $urandom};
    frame_valid = 1; tick(); frame_valid = 0;
    checks++; if (push_data !== 32'hA50004FF) begin errors++; $display("FAIL sat_hdr_drops got %h exp a50004ff", push_data); end
    n = 0; while (busy && n < 100) begin tick(); n++; end
    enable = 0; frame_valid = 1;
    repeat (65540) tick();
    frame_valid = 0;
    checks++; if (frames_dropped !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", frames_dropped); end
    drop_clear = 1; frame_valid = 1; tick(); drop_clear = 0; frame_valid = 0;
    checks++; if (frames_dropped !== 16'd1) begin errors++; $display("FAIL clear_with_drop got %h exp 0001", frames_dropped); end
    drop_clear = 1; tick(); drop_clear = 0;
    checks++; if (frames_dropped !== 16'd0) begin errors++; $display("FAIL clear_alone got %h exp 0000", frames_dropped); end
    enable = 1;
  endtask

  task automatic test_random();
    int n, mis;
    do_reset();
    for (int k = 0; k < 800; k++) begin
      frame_valid = ($urandom_range(3) == 0);
      frame_data  = {$urandom, $urandom, $urandom};
      push_ready  = ($urandom_range(3) != 0);
      enable      = ($urandom_range(7) != 0);
      drop_clear  = ($urandom_range(31) == 0);
      fifo_level  = $urandom_range(1) ? LW'($urandom_range(DEPTH)) : LW'($urandom_range(DEPTH, DEPTH - 8));
      tick();
    end
    frame_valid = 0; push_ready = 1; drop_clear = 0;
    n = 0; while (busy && n < 100) begin tick(); n++; end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_idle_timeout got busy=%0b exp 0", busy); end
    mis = 0;
    if (got_q.size() != exp_q.size()) mis = 1; else foreach (got_q[i]) if (got_q[i] !== exp_q[i]) mis++;
    checks++; if (mis != 0) begin errors++; $display("FAIL rand_stream got %0d words exp %0d (%0d bad)", got_q.size(), exp_q.size(), mis); end
    checks++; if (frames_dropped !== m_fdrop) begin errors++; $display("FAIL rand_dropped got %0d exp %0d", frames_dropped, m_fdrop); end
    checks++; if (m_vmis != 0) begin errors++; $display("FAIL rand_valid got %0d bad cycles exp 0", m_vmis); end
  endtask

  task automatic test_reset_mid_frame();
    rst8 = 1; fv8 = 0; tick(); tick(); rst8 = 0;
    fd8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    fv8 = 1; tick(); fv8 = 0;                            // T+1 header
    checks++; if (pv8 !== 1'b1 || pd8 !== 32'hA5000800) begin errors++; $display("FAIL mid_first_hdr got v=%0b %h exp v=1 a5000800", pv8, pd8); end
    tick(); tick();                                      // T+3: header+2
    rst8 = 1; tick(); rst8 = 0;
    checks++; if (pv8 !== 1'b0 || busy8 !== 1'b0 || pd8 !== 32'h0) begin errors++; $display("FAIL mid_reset got v=%0b busy=%0b %h exp 0 0 0", pv8, busy8, pd8); end
    fd8 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    fv8 = 1; tick(); fv8 = 0;
    checks++; if (pv8 !== 1'b1 || pd8 !== 32'hA5000800) begin errors++; $display("FAIL mid_next_hdr got v=%0b %h exp v=1 a5000800", pv8, pd8); end
    tick();
    checks++; if (pd8 !== {8'h00, fd8[23:0]}) begin errors++; $display("FAIL mid_next_ch0 got %h exp %h", pd8, {8'h00, fd8[23:0]}); end
  endtask

  initial begin
    rst8 = 1; fv8 = 0; fd8 = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_space_check();
    test_drop_during_frame();
    test_saturation();
    test_random();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_frame_packer.md
# adc_frame_packer

Packs one multi-channel ADC conversion frame into a sequence of tagged 32-bit words: one header followed by one word per channel. Pushes that sequence into the ADC stream FIFO through its push_valid/push_ready port. Sits directly upstream of the FIFO, downstream of the ADC capture front-end that presents complete frames. A frame is accepted only when the FIFO has room for all of it, so the FIFO never holds a partial frame. Rejected frames are counted.

## Interface
Parameters:
- NUM_CH, 8: channels per frame; legal range 1..16.
- FIFO_DEPTH, 64: depth of the downstream FIFO in words; sets the width of fifo_level.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- enable  in  1  accept new frames when high
- frame_valid  in  1  single-cycle strobe, frame_data valid
- frame_data  in  NUM_CH*24  channel c sample at bits [24c+23:24c], two's complement
- push_valid  out  1  word available to FIFO
- push_data  out  32  word to FIFO
- push_ready  in  1  FIFO can accept
- fifo_level  in  $clog2(FIFO_DEPTH+1)  FIFO occupancy in words
- busy  out  1  frame emission in progress (state != IDLE)
- frames_dropped  out  16  saturating count of rejected frames
- drop_clear  in  1  zero frames_dropped

## Operation
- Word formats:
  - Header: [31:24]=8'hA5, [23:16]=seq, [15:8]=NUM_CH, [7:0]=drops_since_hdr.
  - Data word for channel c: [31:24]=c, [23:0]=sample c.
- Frame acceptance. In IDLE, a frame_valid is accepted iff enable=1 and (FIFO_DEPTH - fifo_level) >= NUM_CH+1.
  - On accept: latch frame_data into an internal register and go to HDR.
  - Otherwise: drop the frame.
- A frame_valid seen in HDR or DATA is always dropped.
- FSM:
  - IDLE -> HDR on accept.
  - HDR: push_valid=1, push_data=header. On handshake (push_valid & push_ready), go to DATA with ch=0.
  - DATA: push_valid=1, push_data=data word ch. On handshake, ch increments. Handshake with ch=NUM_CH-1 goes to IDLE.
- push_valid and push_data are held stable while push_ready=0.
- Counters:
  - seq: 8 bits, increments on header handshake, wraps 255->0.
  - drops_since_hdr: 8 bits, saturates at 255, increments per drop. Header handshake loads 0, or loads 1 if a drop occurs in that same cycle.
  - frames_dropped: 16 bits, saturates at 65535. drop_clear together with a drop gives 1; drop_clear alone gives 0.
- Deasserting enable mid-frame does not abort the frame: it completes, and later frames are dropped.

## Timing
- Reset values:
  - push_valid=0, push_data=0, busy=0, frames_dropped=0.
  - seq=0, drops_since_hdr=0, ch=0, state=IDLE.
- push_data is 0 whenever push_valid=0.
- Frame accepted at cycle T: header is presented from T+1. With push_ready held high, data words appear at T+2..T+1+NUM_CH and state is IDLE at T+2+NUM_CH.
- Minimum accepted frame period is NUM_CH+2 cycles. A frame arriving at T+1+NUM_CH (the last-data cycle) is dropped.
- The free-space check uses fifo_level as sampled in the accept cycle. Because this block is the FIFO's only writer, no other push is in flight at that point.
- Reset mid-frame: the next cycle shows push_valid=0 and state IDLE. Words already pushed stay in the FIFO, and firmware resyncs on the 8'hA5 header.
- Output registers: push_valid and push_data come from the state and latched-frame registers only. There is no combinational path from frame_* to push_*.

## Structure
- Shared package adc_pkg holds:
  - ADC_HDR_MAGIC (8'hA5)
  - ADC_SAMPLE_W (24)
  - header field offsets
  - packer state enum {IDLE, HDR, DATA}
- These constants are shared with the FIFO drain logic and the firmware header definitions.
- Single module, no sub-module. The saturating counters are simple enough to write inline.

## Test plan
- NUM_CH=4, FIFO empty, push_ready=1, one frame with samples 0x000001, 0xFFFFFF, 0x7FFFFF, 0x800000 -> expect:
  - header 0xA5000400 at T+1
  - 0x00000001, 0x01FFFFFF, 0x027FFFFF, 0x03800000 at T+2..T+5
  - busy low at T+6
- Backpressure: push_ready low for 3 cycles during channel 1 -> push_data stays 0x01FFFFFF throughout, no word lost or duplicated, seq=1 on the next header.
- Space check: fifo_level=FIFO_DEPTH-4 with NUM_CH=4 -> frame dropped, frames_dropped=1. Next accepted header has [7:0]=0x01.
- Frame strobe during DATA, and a second strobe on the last-data cycle -> both dropped, frames_dropped=2, emitted frame intact.
- Saturation and clear:
  - 300 consecutive drops -> next header [7:0]=0xFF.
  - frames_dropped preloaded near 65535 via repeated drops -> holds at 0xFFFF.
  - drop_clear with a simultaneous drop -> 1.
- Reset asserted at header+2 of an 8-channel frame -> push_valid=0 next cycle, seq=0. The next frame emits a header with seq=0.
